// File: rtl/bit_reg_pkg.sv
// Shared widths for the storage hierarchy built on bit_reg.
package bit_reg_pkg;
    localparam int BIT_W  = 1;
    localparam int WORD_W = 16;
endpackage

// File: rtl/bit_reg_dff_arn.sv
// WIDTH-bit D flip-flop with asynchronous active-low reset to RESET_VALUE.
module dff_arn #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/bit_reg.sv
// Load-enabled storage register (Hack "Bit" cell, widened by WIDTH).
module bit_reg
    import bit_reg_pkg::*;
#(
    parameter int              WIDTH       = BIT_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] next_value;

    // Hold by recirculating the stored value; no clock gating.
    assign next_value = load ? in : out;

    dff_arn #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RESET_VALUE)
    ) u_dff (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (next_value),
        .q    (out)
    );

endmodule

// File: tb/tb_bit_reg.sv
// Directed bench for bit_reg: 1-bit cell and 16-bit word instance.
module tb_bit_reg;
    import bit_reg_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              load1;
    logic [BIT_W-1:0]  in1;
    logic [BIT_W-1:0]  out1;
    logic              load16;
    logic [WORD_W-1:0] in16;
    logic [WORD_W-1:0] out16;

    int errors = 0;
    int checks = 0;

    bit_reg u_bit (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load1),
        .in   (in1),
        .out  (out1)
    );

    bit_reg #(.WIDTH(WORD_W)) u_word (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load16),
        .in   (in16),
        .out  (out16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic pat [5];
    logic prev;

    initial begin
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;

        // Reset held with load active and clocks running
        rst_n  = 1'b0;
        load1  = 1'b1;
        in1    = 1'b1;
        load16 = 1'b1;
        in16   = 16'hFFFF;
        #1;
        check("reset_async_bit", {15'd0, out1}, 16'h0000);
        check("reset_async_word", out16, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold_bit", {15'd0, out1}, 16'h0000);
        end
        check("reset_hold_word", out16, 16'h0000);

        // Release between edges with load low
        load1  = 1'b0;
        load16 = 1'b0;
        rst_n  = 1'b1;
        tick();
        check("post_release_bit", {15'd0, out1}, 16'h0000);
        check("post_release_word", out16, 16'h0000);

        // Load 0 then hold
        in1   = 1'b0;
        load1 = 1'b1;
        tick();
        check("load0", {15'd0, out1}, 16'h0000);
        in1   = 1'b1;
        load1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold0", {15'd0, out1}, 16'h0000);
        end

        // Load 1 then hold against both input values
        load1 = 1'b1;
        tick();
        check("load1", {15'd0, out1}, 16'h0001);
        in1   = 1'b0;
        load1 = 1'b0;
        tick();
        check("hold1_in0", {15'd0, out1}, 16'h0001);
        in1 = 1'b1;
        tick();
        check("hold1_in1", {15'd0, out1}, 16'h0001);

        // Glitches during clk-low phase, load back low before the edge
        @(negedge clk);
        #1;
        check("negedge_noeffect", {15'd0, out1}, 16'h0001);
        in1   = 1'b0;
        load1 = 1'b1;
        #1;
        check("glitch_nochange", {15'd0, out1}, 16'h0001);
        in1 = 1'b1;
        #1;
        in1   = 1'b0;
        load1 = 1'b0;
        tick();
        check("glitch_after_edge", {15'd0, out1}, 16'h0001);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", {15'd0, out1}, 16'h0000);
        rst_n = 1'b1;
        in1   = 1'b1;
        load1 = 1'b1;
        tick();
        check("reload1", {15'd0, out1}, 16'h0001);

        // Reset asserted at the same instant as a loading edge
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_vs_load", {15'd0, out1}, 16'h0000);
        tick();
        check("reset_vs_load_hold", {15'd0, out1}, 16'h0000);
        rst_n = 1'b1;
        load1 = 1'b0;

        // Continuous load: out trails in by one edge
        load1 = 1'b1;
        prev  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in1 = pat[i];
            #1;
            check("stream_pre_edge", {15'd0, out1}, {15'd0, prev});
            tick();
            check("stream_post_edge", {15'd0, out1}, {15'd0, pat[i]});
            prev = pat[i];
        end
        load1 = 1'b0;

        // 16-bit word instance
        in16   = 16'hA5C3;
        load16 = 1'b1;
        #1;
        check("word_pre_edge", out16, 16'h0000);
        tick();
        check("word_load", out16, 16'hA5C3);
        in16   = 16'h5A3C;
        load16 = 1'b0;
        tick();
        check("word_hold", out16, 16'hA5C3);
        load16 = 1'b1;
        tick();
        check("word_reload", out16, 16'h5A3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_reg.md
Name: bit_reg

Overview:
- Single-bit (parameterizable-width) storage register with load enable, equivalent to the Hack-platform "Bit" chip.
- Holds its value until `load` is asserted. On a clock edge with `load` high it captures `in`.
- Sits below word registers, RAM cells and the program counter in the memory hierarchy.
- Output is purely registered, with no combinational path from `in` or `load` to `out`.

Parameters:
- WIDTH, 1, number of stored bits; `in` and `out` are WIDTH wide. The default instance is the 1-bit cell.
- RESET_VALUE, 0 (WIDTH bits), value forced onto `out` while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  write enable, sampled on the rising edge of clk.
- in  input  WIDTH  data to store.
- out  output  WIDTH  stored value.

Behaviour:
- Reset:
  - rst_n low sets `out` to RESET_VALUE immediately, without waiting for a clock edge.
  - `out` stays at RESET_VALUE for as long as rst_n is low, regardless of clk, load or in.
- Reset release:
  - Deassertion is synchronised externally by the system.
  - The first rising clk edge with rst_n high is a normal edge.
- Rising edge of clk with load=1: out(t+1) = in(t), i.e. one-cycle latency.
- Rising edge of clk with load=0: out(t+1) = out(t). The value is held indefinitely.
- Between edges:
  - `out` is stable.
  - Changes on `in` or `load` away from a rising edge have no effect. This includes glitches during the low phase of clk.
- The falling edge of clk has no effect.
- Reset asserted in the same instant as a loading edge: reset wins and `out` equals RESET_VALUE.
- `load` held high continuously: `out` follows `in` delayed by exactly one clock.
- Structure:
  - Next-state logic is the 2:1 selection load ? in : out.
  - It feeds a resettable D flip-flop.
  - No latches and no gated clocks.
- Width rules:
  - No arithmetic is performed.
  - All WIDTH bits update together under the single `load`.
- `out` never goes X/Z after reset has been applied once.
- Synthesis result must be WIDTH flip-flops plus enable logic only.

Decomposition:
- Shared package: none required. WIDTH and RESET_VALUE are local parameters of the block.
- One natural sub-module, `dff_arn`: a WIDTH-bit D flip-flop with asynchronous active-low reset to RESET_VALUE.
- `bit_reg` contains the load mux and instantiates `dff_arn`.
- Higher-level register and RAM blocks instantiate `bit_reg` (WIDTH=16 for a word register).

Test Plan:
- Reset: rst_n=0 with load=1, in=1, clocks running -> out=0 throughout. Release rst_n -> out stays 0 until the first loading edge.
- Load 0: in=0, load=1, rising edge -> out=0 after the edge. Then in=1, load=0 for 3 edges -> out stays 0.
- Load 1: in=1, load=1, rising edge -> out=1. Then in=0, load=0, next edge -> out=1 (held). Then in=1, load=0 -> out=1.
- Mid-cycle insensitivity: with out=1, toggle in and load during the clk-low phase and return load=0 before the rising edge -> out remains 1. No change on the falling edge.
- Asynchronous reset mid-operation: with out=1, pull rst_n low between edges -> out=0 within the same time step, with no clock needed. Asserting reset together with a loading edge (in=1) -> out=0.
- Continuous load: load=1, in pattern 1,0,1,1,0 on successive cycles -> out shows 1,0,1,1,0 each delayed by one rising edge. Repeat with WIDTH=16, in=16'hA5C3 -> out=16'hA5C3 one edge later.
